// File: rtl/axis_mult_arbiter.sv
// axis_mult_arbiter: two-source AXI-Stream packet arbiter sharing one axis_multiplier.
// Packets are granted round-robin and never interleaved. Each source's weight is
// latched at grant time. Beats pass through one registered output stage. A beat
// watchdog force-terminates packets that reach MAX_BEATS without tlast.
// Optional feature: define AXIS_ARB_STATS_EN to build the per-source packet counters
// pkt_cnt0/pkt_cnt1. When it is undefined, both counters are tied to zero.
module axis_mult_arbiter #(
  parameter int SDATA_WIDTH  = 128,
  parameter int WEIGHT_WIDTH = 8,
  parameter int MAX_BEATS    = 64
) (
  input  logic                    CLK,
  input  logic                    resetn,
  input  logic [SDATA_WIDTH-1:0]  s0_axis_tdata,
  input  logic                    s0_axis_tvalid,
  input  logic                    s0_axis_tlast,
  output logic                    s0_axis_tready,
  input  logic [SDATA_WIDTH-1:0]  s1_axis_tdata,
  input  logic                    s1_axis_tvalid,
  input  logic                    s1_axis_tlast,
  output logic                    s1_axis_tready,
  input  logic [WEIGHT_WIDTH-1:0] w0,
  input  logic [WEIGHT_WIDTH-1:0] w1,
  output logic [SDATA_WIDTH-1:0]  m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [WEIGHT_WIDTH-1:0] m_weight,
  output logic                    m_src_id,
  output logic                    err_len,
  output logic [15:0]             pkt_cnt0,
  output logic [15:0]             pkt_cnt1
);

  localparam int CNT_W = $clog2(MAX_BEATS) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_last_grant;
  logic [CNT_W-1:0]        r_beat_cnt;
  logic [WEIGHT_WIDTH-1:0] r_weight;
  logic [SDATA_WIDTH-1:0]  r_tdata;
  logic                    r_tvalid;
  logic                    r_tlast;
  logic                    r_src_id;
  logic                    r_err_len;

  logic                    w_out_ready;
  logic                    w_grant;
  logic                    w_grant_src;
  logic                    w_accept;
  logic                    w_sel_src;
  logic [SDATA_WIDTH-1:0]  w_beat_data;
  logic                    w_beat_last;
  logic                    w_at_max;
  logic                    w_force_last;

  // The output register can take a new beat when it is empty or draining this cycle.
  assign w_out_ready  = m_axis_tready | ~r_tvalid;
  assign w_at_max     = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign w_force_last = w_at_max & ~w_beat_last;

  // Next-state, grant decision, source ready and beat selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant        = 1'b0;
    w_grant_src    = 1'b0;
    w_accept       = 1'b0;
    w_sel_src      = 1'b0;
    w_beat_data    = s0_axis_tdata;
    w_beat_last    = s0_axis_tlast;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (r_state)
      IDLE: begin
        // Hold off a new grant (and its weight update) until the previous
        // packet's final output beat has been handshaken.
        if (w_out_ready) begin
          if (s0_axis_tvalid && s1_axis_tvalid) begin
            w_grant     = 1'b1;
            w_grant_src = ~r_last_grant;
          end else if (s0_axis_tvalid) begin
            w_grant     = 1'b1;
            w_grant_src = 1'b0;
          end else if (s1_axis_tvalid) begin
            w_grant     = 1'b1;
            w_grant_src = 1'b1;
          end
        end
        if (w_grant) begin
          w_state_nxt = w_grant_src ? GRANT1 : GRANT0;
        end
      end
      GRANT0: begin
        s0_axis_tready = w_out_ready;
        w_accept       = s0_axis_tvalid & w_out_ready;
        w_sel_src      = 1'b0;
        w_beat_data    = s0_axis_tdata;
        w_beat_last    = s0_axis_tlast;
      end
      GRANT1: begin
        s1_axis_tready = w_out_ready;
        w_accept       = s1_axis_tvalid & w_out_ready;
        w_sel_src      = 1'b1;
        w_beat_data    = s1_axis_tdata;
        w_beat_last    = s1_axis_tlast;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_accept && (w_beat_last || w_at_max)) begin
      w_state_nxt = IDLE;
    end
  end

  // State, round-robin pointer, beat counter and weight latched at grant.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= '0;
      r_weight     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_last_grant <= w_grant_src;
        r_beat_cnt   <= '0;
        r_weight     <= w_grant_src ? w1 : w0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

  // Registered output stage; tlast is forced on the watchdog beat.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_src_id <= 1'b0;
    end else if (w_accept) begin
      r_tdata  <= w_beat_data;
      r_tvalid <= 1'b1;
      r_tlast  <= w_beat_last | w_force_last;
      r_src_id <= w_sel_src;
    end else if (r_tvalid && m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  // Sticky length error, cleared only by reset.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_err_len <= 1'b0;
    end else if (w_accept && w_force_last) begin
      r_err_len <= 1'b1;
    end
  end

`ifdef AXIS_ARB_STATS_EN
  logic [15:0] r_pkt_cnt0;
  logic [15:0] r_pkt_cnt1;

  // Count completed output packets per source, forced terminations included.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_pkt_cnt0 <= '0;
      r_pkt_cnt1 <= '0;
    end else if (r_tvalid && m_axis_tready && r_tlast) begin
      if (r_src_id) r_pkt_cnt1 <= r_pkt_cnt1 + 16'd1;
      else          r_pkt_cnt0 <= r_pkt_cnt0 + 16'd1;
    end
  end

  assign pkt_cnt0 = r_pkt_cnt0;
  assign pkt_cnt1 = r_pkt_cnt1;
`else
  assign pkt_cnt0 = 16'd0;
  assign pkt_cnt1 = 16'd0;
`endif

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_weight      = r_weight;
  assign m_src_id      = r_src_id;
  assign err_len       = r_err_len;

endmodule

// File: tb/tb_axis_mult_arbiter.sv
// Testbench for axis_mult_arbiter: queue-based source drivers and an output
// scoreboard, with directed scenarios followed by a randomized phase.
module tb_axis_mult_arbiter;
  localparam int DW = 128;
  localparam int WW = 8;
  localparam int MAXB = 64;

  logic          CLK;
  logic          resetn;
  logic [DW-1:0] s0_axis_tdata, s1_axis_tdata;
  logic          s0_axis_tvalid, s1_axis_tvalid;
  logic          s0_axis_tlast, s1_axis_tlast;
  logic          s0_axis_tready, s1_axis_tready;
  logic [WW-1:0] w0, w1;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [WW-1:0] m_weight;
  logic          m_src_id, err_len;
  logic [15:0]   pkt_cnt0, pkt_cnt1;

  axis_mult_arbiter #(.SDATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .MAX_BEATS(MAXB)) dut (
    .CLK(CLK), .resetn(resetn),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .w0(w0), .w1(w1),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .m_weight(m_weight), .m_src_id(m_src_id), .err_len(err_len),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [WW-1:0] wv;
  } in_beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [WW-1:0] w;
  } out_beat_t;

  in_beat_t  inq0[$], inq1[$];
  out_beat_t exq0[$], exq1[$];
  int        hs_src[$], hs_cyc[$];
  int        n_assert = 0, n_fail = 0;
  int        cyc = 0;
  int        exp_cnt0 = 0, exp_cnt1 = 0;
  logic      in_pkt = 0, cur_src = 0;
  logic      stall_prev = 0;
  logic [DW-1:0] prev_data;
  logic      prev_last, prev_src;
  logic [WW-1:0] prev_w;
  logic      hs0, hs1;
  int        rdy_mode = 0;
  logic      rdy_force = 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Build one input packet and its expected output beats. A new arbitration starts
  // every MAXB beats, so the source weight is only meaningful on those beats;
  // elsewhere it carries junk that must be ignored.
  task automatic push_pkt(input int src, input int len, input logic [WW-1:0] w);
    for (int i = 0; i < len; i++) begin
      in_beat_t  ib;
      out_beat_t ob;
      ib.data = {$urandom, $urandom, $urandom, $urandom};
      ib.last = (i == len - 1);
      ib.wv   = ((i % MAXB) == 0) ? w : WW'($urandom_range(0, 255));
      ob.data = ib.data;
      ob.last = ib.last || ((i % MAXB) == MAXB - 1);
      ob.w    = w;
      if (src == 0) begin inq0.push_back(ib); exq0.push_back(ob); end
      else          begin inq1.push_back(ib); exq1.push_back(ob); end
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_tvalid"}, m_axis_tvalid, 0);
    chk({pfx, "_tlast"}, m_axis_tlast, 0);
    chk({pfx, "_tdata"}, m_axis_tdata, 0);
    chk({pfx, "_weight"}, m_weight, 0);
    chk({pfx, "_src"}, m_src_id, 0);
    chk({pfx, "_err"}, err_len, 0);
    chk({pfx, "_cnt0"}, pkt_cnt0, 0);
    chk({pfx, "_cnt1"}, pkt_cnt1, 0);
    chk({pfx, "_treadys"}, {s0_axis_tready, s1_axis_tready}, 0);
  endtask

  task automatic apply_reset();
    @(posedge CLK);
    #2;
    resetn = 0;
    inq0.delete(); inq1.delete(); exq0.delete(); exq1.delete();
    hs_src.delete(); hs_cyc.delete();
    in_pkt = 0; stall_prev = 0; exp_cnt0 = 0; exp_cnt1 = 0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((inq0.size() + inq1.size() + exq0.size() + exq1.size()) != 0 && n < 5000) begin
      @(posedge CLK);
      n++;
    end
    chk({tag, "_drain_timeout"}, (n < 5000), 1);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Downstream ready: fixed value or random per cycle.
  initial begin
    m_axis_tready = 1;
    forever begin
      @(posedge CLK);
      #2;
      m_axis_tready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Source 0 driver.
  initial begin
    s0_axis_tvalid = 0; s0_axis_tdata = '0; s0_axis_tlast = 0; w0 = '0;
    forever begin
      @(negedge CLK);
      hs0 = s0_axis_tvalid & s0_axis_tready;
      @(posedge CLK);
      #1;
      if (hs0 && inq0.size() > 0) void'(inq0.pop_front());
      if (inq0.size() > 0) begin
        s0_axis_tvalid = 1; s0_axis_tdata = inq0[0].data;
        s0_axis_tlast = inq0[0].last; w0 = inq0[0].wv;
      end else begin
        s0_axis_tvalid = 0;
      end
    end
  end

  // Source 1 driver.
  initial begin
    s1_axis_tvalid = 0; s1_axis_tdata = '0; s1_axis_tlast = 0; w1 = '0;
    forever begin
      @(negedge CLK);
      hs1 = s1_axis_tvalid & s1_axis_tready;
      @(posedge CLK);
      #1;
      if (hs1 && inq1.size() > 0) void'(inq1.pop_front());
      if (inq1.size() > 0) begin
        s1_axis_tvalid = 1; s1_axis_tdata = inq1[0].data;
        s1_axis_tlast = inq1[0].last; w1 = inq1[0].wv;
      end else begin
        s1_axis_tvalid = 0;
      end
    end
  end

  // Output scoreboard, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (resetn) begin
        chk("tready_exclusive", s0_axis_tready & s1_axis_tready, 0);
        if (m_axis_tvalid && !m_axis_tready)
          chk("stall_src_tready", {s0_axis_tready, s1_axis_tready}, 0);
        if (stall_prev && m_axis_tvalid) begin
          chk("stall_data_stable", m_axis_tdata, prev_data);
          chk("stall_last_stable", m_axis_tlast, prev_last);
          chk("stall_src_stable", m_src_id, prev_src);
          chk("stall_weight_stable", m_weight, prev_w);
        end
        stall_prev = m_axis_tvalid & ~m_axis_tready;
        prev_data = m_axis_tdata; prev_last = m_axis_tlast;
        prev_src = m_src_id; prev_w = m_weight;
        if (m_axis_tvalid && m_axis_tready) begin
          out_beat_t eb;
          logic      have;
          hs_src.push_back(int'(m_src_id));
          hs_cyc.push_back(cyc);
          if (in_pkt) chk("no_interleave", m_src_id, cur_src);
          have = 0;
          if (m_src_id == 0 && exq0.size() > 0) begin eb = exq0.pop_front(); have = 1; end
          if (m_src_id == 1 && exq1.size() > 0) begin eb = exq1.pop_front(); have = 1; end
          chk("beat_expected", have, 1);
          if (have) begin
            chk("out_data", m_axis_tdata, eb.data);
            chk("out_last", m_axis_tlast, eb.last);
            chk("out_weight", m_weight, eb.w);
            if (eb.last) begin
              if (m_src_id) exp_cnt1++; else exp_cnt0++;
            end
          end
          in_pkt  = ~m_axis_tlast;
          cur_src = m_src_id;
        end
      end
    end
  end

  initial begin
    int exp_src[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int exp_gap[7] = '{1, 2, 1, 2, 1, 2, 1};
    resetn = 0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_vals("reset");
    @(negedge CLK);
    resetn = 1;

    // Single 4-beat packet from source 0 at full rate.
    @(posedge CLK); #1;
    hs_src.delete(); hs_cyc.delete();
    push_pkt(0, 4, 8'h40);
    wait_drain("t1");
    chk("t1_beats", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4)
      for (int i = 0; i < 3; i++) chk("t1_consecutive", hs_cyc[i+1] - hs_cyc[i], 1);
    chk("t1_weight", m_weight, 8'h40);
    chk("t1_src", m_src_id, 0);
    chk("t1_final_tlast", m_axis_tlast, 1);
    chk("t1_tvalid_idle", m_axis_tvalid, 0);

    // Both sources pending from reset: alternate grants with one bubble each.
    apply_reset();
    push_pkt(0, 2, 8'h10); push_pkt(0, 2, 8'h10);
    push_pkt(1, 2, 8'h20); push_pkt(1, 2, 8'h20);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    resetn = 1;
    wait_drain("t2");
    chk("t2_beats", hs_src.size(), 8);
    if (hs_src.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("t2_order", hs_src[i], exp_src[i]);
      for (int i = 0; i < 7; i++) chk("t2_gap", hs_cyc[i+1] - hs_cyc[i], exp_gap[i]);
    end

    // Backpressure pattern 1,0,0,1 in the middle of a packet.
    hs_src.delete(); hs_cyc.delete();
    push_pkt(0, 4, 8'h33);
    for (int n = 0; n < 100 && hs_src.size() < 1; n++) begin @(posedge CLK); #1; end
    chk("t3_first_beat_seen", hs_src.size() >= 1, 1);
    rdy_force = 1; @(posedge CLK); #1;
    rdy_force = 0; @(posedge CLK); #1;
    rdy_force = 0; @(posedge CLK); #1;
    rdy_force = 1;
    wait_drain("t3");
    chk("t3_beats", hs_src.size(), 4);

    // Random traffic with random downstream backpressure.
    rdy_mode = 1;
    for (int k = 0; k < 24; k++)
      push_pkt($urandom_range(0, 1), $urandom_range(1, 10), WW'($urandom_range(0, 255)));
    wait_drain("rand");
    rdy_mode = 0;
    chk("rand_err_len", err_len, 0);
`ifdef AXIS_ARB_STATS_EN
    chk("rand_cnt0", pkt_cnt0, exp_cnt0);
    chk("rand_cnt1", pkt_cnt1, exp_cnt1);
`else
    chk("rand_cnt0", pkt_cnt0, 0);
    chk("rand_cnt1", pkt_cnt1, 0);
`endif

    // Runaway packet: 70 beats from source 1, tlast only on the 70th.
    hs_src.delete(); hs_cyc.delete();
    chk("t4_err_before", err_len, 0);
    push_pkt(1, 70, 8'h5A);
    wait_drain("t4");
    chk("t4_err_after", err_len, 1);
    chk("t4_beats", hs_cyc.size(), 70);
    if (hs_cyc.size() == 70) chk("t4_rearb_gap", hs_cyc[64] - hs_cyc[63], 2);

    // Reset in the middle of a packet, then source 0 must win after release.
    hs_src.delete(); hs_cyc.delete();
    push_pkt(0, 4, 8'h11);
    for (int n = 0; n < 100 && hs_src.size() < 1; n++) begin @(posedge CLK); #1; end
    chk("t5_pkt_started", m_axis_tvalid, 1);
    apply_reset();
    #1;
    check_reset_vals("midrst");
    push_pkt(0, 3, 8'h01); push_pkt(0, 2, 8'h02);
    push_pkt(1, 3, 8'h03); push_pkt(1, 1, 8'h04);
    push_pkt(0, 2, 8'h05);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    resetn = 1;
    wait_drain("t6");
    chk("t5_first_src", (hs_src.size() > 0) ? hs_src[0] : -1, 0);
`ifdef AXIS_ARB_STATS_EN
    chk("t6_cnt0", pkt_cnt0, 3);
    chk("t6_cnt1", pkt_cnt1, 2);
`else
    chk("t6_cnt0", pkt_cnt0, 0);
    chk("t6_cnt1", pkt_cnt1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
